// File: rtl/jtag_sync_pkg.sv
// Shared types and parameter limits for the JTAG pad front-end.
// The RTCK FSM encoding lives here so checkers can decode the state.
package jtag_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HOLD  = 2'd2
  } rtck_state_e;

  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;
  localparam int FILTER_MIN = 1;
  localparam int FILTER_MAX = 15;
  localparam int DELAY_MIN  = 0;
  localparam int DELAY_MAX  = 15;

  function automatic bit params_legal(input int sync_stages, input int filter_len,
                                      input int rtck_delay, input int timeout_w);
    return (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
           (filter_len >= FILTER_MIN) && (filter_len <= FILTER_MAX) &&
           (rtck_delay >= DELAY_MIN) && (rtck_delay <= DELAY_MAX) &&
           (timeout_w >= 1);
  endfunction

endpackage

// File: rtl/jtag_sync_cell.sv
// N-stage synchroniser; the async reset drives every stage to RST_VAL,
// which gives the async-assert / sync-release form when RST_VAL=1.
module jtag_sync_cell #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/jtag_rtck_sync.sv
// JTAG pad front-end: synchronises and deglitches the pads, emits TCK edge
// strobes to a clk_i-domain TAP and produces a throttleable return clock.
module jtag_rtck_sync
  import jtag_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int RTCK_DELAY  = 0,
  parameter int TIMEOUT_W   = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  input  logic ntrst_i,
  input  logic stall_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o,
  output logic trst_o,
  output logic rtck_o,
  output logic glitch_o,
  output logic idle_o
);

  if (!params_legal(SYNC_STAGES, FILTER_LEN, RTCK_DELAY, TIMEOUT_W)) begin : g_bad_params
    $error("jtag_rtck_sync: parameter out of legal range");
  end

  localparam logic [4:0] FILT_LAST = 5'(FILTER_LEN);
  localparam logic [3:0] DLY_LOAD  = 4'((RTCK_DELAY > 0) ? RTCK_DELAY - 1 : 0);

  logic w_tck_s, w_tms_s, w_tdi_s, w_trst, w_trst_arst;
  logic w_diff, w_acc;

  logic                 r_tck_filt;
  logic [3:0]           r_filt_cnt;
  logic                 r_rise, r_fall, r_glitch;
  logic                 r_tms, r_tdi;
  logic                 r_rtck;
  rtck_state_e          r_state;
  logic [3:0]           r_dly_cnt;
  logic [TIMEOUT_W-1:0] r_idle_cnt;

  assign w_trst_arst = rst_i | ~ntrst_i;

  jtag_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tck (
    .i_clk(clk_i), .i_arst(rst_i), .i_d(tck_i), .o_q(w_tck_s));
  jtag_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tms (
    .i_clk(clk_i), .i_arst(rst_i), .i_d(tms_i), .o_q(w_tms_s));
  jtag_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_tdi (
    .i_clk(clk_i), .i_arst(rst_i), .i_d(tdi_i), .o_q(w_tdi_s));
  // Shifting zeros out of a set chain releases trst SYNC_STAGES cycles after ntrst rises.
  jtag_sync_cell #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_trst (
    .i_clk(clk_i), .i_arst(w_trst_arst), .i_d(1'b0), .o_q(w_trst));

  assign w_diff = w_tck_s ^ r_tck_filt;
  assign w_acc  = w_diff && (({1'b0, r_filt_cnt} + 5'd1) == FILT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tck_filt <= 1'b0;
      r_filt_cnt <= 4'd0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_glitch   <= 1'b0;
      r_tms      <= 1'b1;
      r_tdi      <= 1'b0;
    end else begin
      r_rise   <= w_acc & w_tck_s & ~w_trst;
      r_fall   <= w_acc & ~w_tck_s & ~w_trst;
      r_glitch <= ~w_diff & (r_filt_cnt != 4'd0);
      if (w_acc) begin
        r_tck_filt <= w_tck_s;
        r_filt_cnt <= 4'd0;
      end else if (w_diff) begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end else begin
        r_filt_cnt <= 4'd0;
      end
      if (w_acc && w_tck_s && !w_trst) begin
        r_tms <= w_tms_s;
        r_tdi <= w_tdi_s;
      end
    end
  end

  // A newly accepted edge always restarts the FSM, so rtck settles to r_tck_filt.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_dly_cnt <= 4'd0;
      r_rtck    <= 1'b0;
    end else if (w_acc) begin
      if (RTCK_DELAY > 0) begin
        r_state   <= ST_DELAY;
        r_dly_cnt <= DLY_LOAD;
      end else if (!stall_i) begin
        r_rtck  <= w_tck_s;
        r_state <= ST_IDLE;
      end else begin
        r_state <= ST_HOLD;
      end
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (r_dly_cnt == 4'd0) begin
            if (!stall_i) begin
              r_rtck  <= r_tck_filt;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_HOLD;
            end
          end else begin
            r_dly_cnt <= r_dly_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            r_rtck  <= r_tck_filt;
            r_state <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idle_cnt <= '0;
    end else if (w_acc) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != '1) begin
      r_idle_cnt <= r_idle_cnt + TIMEOUT_W'(1);
    end
  end

  assign tck_rise_o = r_rise;
  assign tck_fall_o = r_fall;
  assign glitch_o   = r_glitch;
  assign tms_o      = r_tms;
  assign tdi_o      = r_tdi;
  assign trst_o     = w_trst;
  assign rtck_o     = r_rtck;
  assign idle_o     = &r_idle_cnt;

endmodule

// File: tb/tb_jtag_rtck_sync.sv
// Bench for jtag_rtck_sync: two instances (default and non-default parameters)
// share the pads; a pad-level reference model predicts every output event.
module tb_jtag_rtck_sync;
  import jtag_sync_pkg::*;

  localparam int W = 25;
  localparam int P_SYNC [2] = '{2, 2};
  localparam int P_FL   [2] = '{2, 3};
  localparam int P_DLY  [2] = '{0, 5};
  localparam int P_TW   [2] = '{16, 4};
  localparam logic [7:0] RST_VEC = 8'b0110_0000;

  logic clk = 1'b0;
  logic rst_i = 1'b1, tck_i = 1'b0, tms_i = 1'b1, tdi_i = 1'b0, ntrst_i = 1'b1, stall_i = 1'b0;
  logic ri0, fa0, tm0, td0, tr0, rt0, gl0, id0;
  logic ri1, fa1, tm1, td1, tr1, rt1, gl1, id1;
  logic [7:0] obs0, obs1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit smp_tck, smp_tms, smp_tdi, smp_ntrst, smp_stall, smp_rst;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  jtag_rtck_sync #(.SYNC_STAGES(P_SYNC[0]), .FILTER_LEN(P_FL[0]), .RTCK_DELAY(P_DLY[0]),
                   .TIMEOUT_W(P_TW[0])) dut0 (
    .clk_i(clk), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .ntrst_i(ntrst_i), .stall_i(stall_i), .tck_rise_o(ri0), .tck_fall_o(fa0),
    .tms_o(tm0), .tdi_o(td0), .trst_o(tr0), .rtck_o(rt0), .glitch_o(gl0), .idle_o(id0));

  jtag_rtck_sync #(.SYNC_STAGES(P_SYNC[1]), .FILTER_LEN(P_FL[1]), .RTCK_DELAY(P_DLY[1]),
                   .TIMEOUT_W(P_TW[1])) dut1 (
    .clk_i(clk), .rst_i(rst_i), .tck_i(tck_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .ntrst_i(ntrst_i), .stall_i(stall_i), .tck_rise_o(ri1), .tck_fall_o(fa1),
    .tms_o(tm1), .tdi_o(td1), .trst_o(tr1), .rtck_o(rt1), .glitch_o(gl1), .idle_o(id1));

  // Event kinds: 0 rise, 1 fall, 2 glitch, 3 rtck, 4 idle, 5 trst, 6 tms, 7 tdi.
  assign obs0 = {td0, tm0, tr0, id0, rt0, gl0, fa0, ri0};
  assign obs1 = {td1, tm1, tr1, id1, rt1, gl1, fa1, ri1};

  // ---------------- clock/reset sampling ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
    smp_tck = tck_i; smp_tms = tms_i; smp_tdi = tdi_i;
    smp_ntrst = ntrst_i; smp_stall = stall_i; smp_rst = rst_i;
  end

  // ---------------- reference model ----------------
  bit h_tck [2][8];
  bit h_tms [2][8];
  bit h_tdi [2][8];
  bit m_filt [2];
  bit m_rise [2];
  bit m_fall [2];
  bit m_glitch [2];
  bit m_rtck [2];
  bit m_pend [2];
  bit m_tms [2];
  bit m_tdi [2];
  bit m_trst [2];
  int m_run [2];
  int m_due [2];
  int m_idle [2];
  int m_hi [2];
  logic [7:0] m_rep [2];

  function automatic logic [W-1:0] ev(input int k, input int kind, input logic val);
    logic [31:0] kk, kd, cc;
    kk = 32'(k); kd = 32'(kind); cc = 32'(cyc);
    return {kk[0], kd[2:0], cc[19:0], val};
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 8; i++) begin
      h_tck[k][i] = 1'b0; h_tms[k][i] = 1'b0; h_tdi[k][i] = 1'b0;
    end
    m_filt[k] = 1'b0; m_run[k] = 0; m_rise[k] = 1'b0; m_fall[k] = 1'b0;
    m_glitch[k] = 1'b0; m_rtck[k] = 1'b0; m_pend[k] = 1'b0; m_due[k] = 0;
    m_idle[k] = 0; m_tms[k] = 1'b1; m_tdi[k] = 1'b0; m_trst[k] = 1'b1; m_hi[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit s, acc, trst_before;
    trst_before = m_trst[k];
    for (int i = 7; i > 0; i--) begin
      h_tck[k][i] = h_tck[k][i-1]; h_tms[k][i] = h_tms[k][i-1]; h_tdi[k][i] = h_tdi[k][i-1];
    end
    h_tck[k][0] = smp_tck; h_tms[k][0] = smp_tms; h_tdi[k][0] = smp_tdi;
    s = h_tck[k][P_SYNC[k]];
    acc = 1'b0;
    m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_glitch[k] = 1'b0;
    // A new level needs FILTER_LEN consecutive differing samples.
    if (s != m_filt[k]) begin
      m_run[k]++;
      if (m_run[k] == P_FL[k]) begin
        acc = 1'b1; m_filt[k] = s; m_run[k] = 0;
      end
    end else if (m_run[k] != 0) begin
      m_run[k] = 0; m_glitch[k] = 1'b1;
    end
    if (acc && !trst_before) begin
      m_rise[k] = s; m_fall[k] = !s;
      if (s) begin
        m_tms[k] = h_tms[k][P_SYNC[k]]; m_tdi[k] = h_tdi[k][P_SYNC[k]];
      end
    end
    if (acc) begin
      m_pend[k] = 1'b1; m_due[k] = cyc + P_DLY[k]; m_idle[k] = 0;
    end else if (m_idle[k] < (1 << 20)) begin
      m_idle[k]++;
    end
    if (m_pend[k] && cyc >= m_due[k] && !smp_stall) begin
      m_rtck[k] = m_filt[k]; m_pend[k] = 1'b0;
    end
    if (!smp_ntrst) m_hi[k] = 0;
    else if (m_hi[k] < 8) m_hi[k]++;
    m_trst[k] = (m_hi[k] < P_SYNC[k]);
  endtask

  function automatic logic [7:0] model_vec(input int k);
    logic idle;
    idle = (m_idle[k] >= (1 << P_TW[k]) - 1);
    return {m_tdi[k], m_tms[k], m_trst[k], idle, m_rtck[k], m_glitch[k], m_fall[k], m_rise[k]};
  endfunction

  initial begin : model_proc
    logic [7:0] v;
    m_rep[0] = RST_VEC; m_rep[1] = RST_VEC;
    model_reset(0); model_reset(1);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (smp_rst) model_reset(k);
        else model_step(k);
        if (rst_i) model_reset(k);
        if (!ntrst_i) begin
          m_trst[k] = 1'b1; m_hi[k] = 0;
        end
        v = model_vec(k);
        for (int kind = 0; kind < 8; kind++) begin
          if ((kind < 3) ? v[kind] : (v[kind] != m_rep[k][kind]))
            exp_q.push_back(ev(k, kind, v[kind]));
        end
        m_rep[k] = v;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor_proc
    logic [7:0] prev [2];
    logic [7:0] v;
    logic [W-1:0] got, e;
    prev[0] = RST_VEC; prev[1] = RST_VEC;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        v = (k == 0) ? obs0 : obs1;
        for (int kind = 0; kind < 8; kind++) begin
          if ((kind < 3) ? v[kind] : (v[kind] != prev[k][kind])) begin
            got = ev(k, kind, v[kind]);
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL event got inst=%0d kind=%0d cyc=%0d val=%0d required none",
                       got[24], got[23:21], got[20:1], got[0]);
            end else begin
              e = exp_q.pop_front();
              if (e !== got) begin
                miscompares++;
                $display("FAIL event got inst=%0d kind=%0d cyc=%0d val=%0d required inst=%0d kind=%0d cyc=%0d val=%0d",
                         got[24], got[23:21], got[20:1], got[0], e[24], e[23:21], e[20:1], e[0]);
              end
            end
          end
        end
        prev[k] = v;
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL event got none required inst=%0d kind=%0d cyc=%0d val=%0d",
                 e[24], e[23:21], e[20:1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  task automatic wait_ev(input int k, input int kind, input int limit);
    logic [7:0] v;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      v = (k == 0) ? obs0 : obs1;
      seen = v[kind];
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL wait_inst%0d_kind%0d got=timeout required=strobe", k, kind);
    end
  endtask

  task automatic tck_pulse(input int hi, input int lo, input logic tms, input logic tdi);
    tms_i = tms; tdi_i = tdi;
    tick();
    tck_i = 1'b1;
    repeat (hi) tick();
    tck_i = 1'b0;
    repeat (lo) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    bit pat [4];
    int hold;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1};

    repeat (4) tick();
    check("rst_outputs_inst0", obs0, RST_VEC);
    check("rst_outputs_inst1", obs1, RST_VEC);
    check("rst_state_inst1", 8'(dut1.r_state), 8'(ST_IDLE));
    rst_i = 1'b0;
    repeat (4) tick();

    // TMS pattern with a 20-cycle TCK
    for (int i = 0; i < 4; i++) tck_pulse(10, 10, pat[i], 1'($urandom_range(0, 1)));

    // 2-cycle TCK pulse: rejected by the FILTER_LEN=3 instance
    tck_pulse(2, 14, 1'b1, 1'b0);

    // stall held across the delayed RTCK update
    tck_i = 1'b1;
    wait_ev(1, 0, 30);
    stall_i = 1'b1;
    repeat (6) tick();
    stall_i = 1'b0;
    repeat (14) tick();

    // nTRST pulse while TCK toggles
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 5 == 0) tck_i = ~tck_i;
      if (i == 12) ntrst_i = 1'b0;
      if (i == 15) ntrst_i = 1'b1;
    end

    // TCK held constant long enough to flag idle, then one edge clears it
    tck_i = 1'b0;
    repeat (25) tick();
    tck_pulse(8, 12, 1'b0, 1'b1);

    // reset while the RTCK_DELAY=5 instance sits in DELAY with rtck high
    tms_i = 1'b0;
    tck_i = 1'b1;
    wait_ev(1, 0, 30);
    repeat (12) tick();
    tck_i = 1'b0;
    wait_ev(1, 1, 30);
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    check("rst_in_delay_rtck", 8'(rt1), 8'd0);
    check("rst_in_delay_tms", 8'(tm1), 8'd1);
    check("rst_in_delay_state", 8'(dut1.r_state), 8'(ST_IDLE));
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (4) tick();

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (hold == 0) begin
        tck_i = ~tck_i;
        hold = int'($urandom_range(1, 14));
      end else begin
        hold--;
      end
      tms_i = 1'($urandom_range(0, 1));
      tdi_i = 1'($urandom_range(0, 1));
      stall_i = ($urandom_range(0, 3) == 0);
      if (ntrst_i == 1'b0) ntrst_i = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 199) == 0) ntrst_i = 1'b0;
      rst_i = ($urandom_range(0, 499) == 0);
    end
    rst_i = 1'b0;
    ntrst_i = 1'b1;
    stall_i = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtag_rtck_sync.md
# jtag_rtck_sync

Parametrised JTAG pad front-end for targets whose TAP runs in the CPU clock domain. It synchronises and deglitches TCK, TMS, TDI and nTRST, and emits one-cycle rise and fall strobes to the TAP core. It generates an adaptive return clock (RTCK) that the core can throttle, and flags glitches and an idle debug link. It sits between the debug pads and the TAP controller, and the transactor's RTCK mode drives it in simulation.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for each pad input; legal range 2..4
- FILTER_LEN, 2, consecutive differing synchronised TCK samples required before a new TCK level is accepted; legal range 1..15
- RTCK_DELAY, 0, extra clk_i cycles between an accepted TCK edge and RTCK following it; legal range 0..15
- TIMEOUT_W, 16, width of the idle counter

Ports:
- clk_i  in  1  CPU clock; must be at least 2*(SYNC_STAGES+FILTER_LEN) times faster than TCK
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- tck_i, tms_i, tdi_i  in  1 each  asynchronous JTAG pads
- ntrst_i  in  1  asynchronous pad, active low
- stall_i  in  1  core busy; holds RTCK at its old level
- tck_rise_o  out  1  one-cycle strobe on an accepted rising TCK edge
- tck_fall_o  out  1  one-cycle strobe on an accepted falling TCK edge
- tms_o, tdi_o  out  1 each  values captured on the rise strobe
- trst_o  out  1  active-high TAP reset
- rtck_o  out  1  return clock
- glitch_o  out  1  one-cycle strobe on a rejected TCK pulse
- idle_o  out  1  set when no edge has been accepted for 2^TIMEOUT_W-1 cycles

## Operation
- Reset values: tck_rise_o=0, tck_fall_o=0, glitch_o=0, idle_o=0, rtck_o=0, tms_o=1, tdi_o=0, trst_o=1. Internally tck_filt=0, filter counter=0, RTCK FSM in IDLE.
- Synchronisation: tck_i, tms_i and tdi_i each pass through SYNC_STAGES flops; the output of the TCK chain is tck_s.
- Filter:
  - If tck_s differs from tck_filt, the counter increments.
  - When counter+1 reaches FILTER_LEN: tck_filt takes tck_s, the counter clears, and the matching strobe is registered.
  - If tck_s equals tck_filt while the counter is non-zero: the counter clears and glitch_o pulses.
  - With FILTER_LEN=1 there is no filtering.
- Capture: on the cycle a rise is accepted, tms_o and tdi_o take the synchronised TMS and TDI values. They hold until the next rise.
- trst_o:
  - Asserts asynchronously when ntrst_i is low.
  - Deasserts SYNC_STAGES clk_i cycles after ntrst_i rises.
  - While trst_o=1, rise and fall strobes and captures are suppressed. The filter and RTCK keep running.
- RTCK FSM, states IDLE, DELAY and HOLD:
  - IDLE, accepted edge: if RTCK_DELAY=0 and stall_i=0, rtck_o takes the new tck_filt in the same cycle as the strobe. If RTCK_DELAY>0, load the delay counter and go to DELAY. Otherwise go to HOLD.
  - DELAY: decrement the counter. At zero, update rtck_o and go to IDLE if stall_i=0, else go to HOLD.
  - HOLD: update rtck_o on the first cycle stall_i=0, then go to IDLE.
  - A new edge accepted in DELAY or HOLD restarts DELAY or HOLD with the newest level. No edge is queued, so RTCK always settles to tck_filt.
- Idle: a saturating counter clears on each accepted edge. idle_o is counter==all-ones; it clears on the next accepted edge.

## Timing
- Pad edge to strobe: SYNC_STAGES+FILTER_LEN clk_i cycles. Jitter is at most +1 cycle.
- Strobe to rtck_o change: RTCK_DELAY cycles, plus each cycle stall_i is high when the update is due.
- Strobes are exactly one cycle wide. A rise strobe and a fall strobe never coincide.
- rst_i asserted mid-operation: all state returns to reset values immediately. After release, the first accepted edge is measured against tck_filt=0.

## Structure
- jtag_sync_pkg holds:
  - the RTCK FSM state enum (IDLE, DELAY, HOLD);
  - the legal parameter limits and elaboration checks.
- Sub-module jtag_sync_cell is an N-stage synchroniser with a parameter for the reset value. It is instantiated four times:
  - for TCK, TMS and TDI, reset value 0;
  - for nTRST, async-set form.

## Test plan
- Default parameters; TCK period 20 clk_i cycles; TMS pattern 1,1,0,1 -> tck_rise_o 4 cycles after each pad rise; tms_o=1,1,0,1; rtck_o follows 4 cycles after the pad.
- FILTER_LEN=3; a 2-cycle TCK high pulse -> no strobe, glitch_o pulses once, rtck_o stays 0.
- RTCK_DELAY=5; stall_i high for 7 cycles starting at the strobe -> rtck_o changes 7 cycles after the strobe, not 5.
- ntrst_i low for 3 cycles during TCK toggling -> trst_o=1 immediately and deasserts 2 cycles after release; no strobes while trst_o=1; rtck_o keeps tracking.
- TIMEOUT_W=4; TCK held constant -> idle_o=1 after 15 cycles; the next accepted edge clears it.
- rst_i asserted while in DELAY -> rtck_o=0 and FSM in IDLE in the same cycle; tms_o=1.
